fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the single-cycle RV64 core datapath, directly upstream of the decode/immediate-generation logic. It holds the program counter and issues word reads to a synchronous instruction memory. Each returned instruction and its PC go out through a valid/ready handshake with a one-entry skid buffer. It accepts taken-branch redirects: the target is computed from the sign-extended B-type immediate (imm[12:1] in bits 11:0) that the immediate generator produces.

## Interface
- RESET_PC, 64'h0, byte address fetched first after reset
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- imem_req  out  1  read strobe; memory returns data the following cycle
- imem_addr  out  64  byte address of the read; always a multiple of 4
- imem_rdata  in  32  read data, valid the cycle after imem_req
- branch_taken  in  1  one-cycle redirect pulse
- branch_pc  in  64  PC of the branch instruction
- branch_imm  in  64  sign-extended halfword offset from the immediate generator
- inst_ready  in  1  downstream accepts the instruction this cycle
- inst_valid  out  1  instruction/pc_out valid
- instruction  out  32  fetched instruction word
- pc_out  out  64  byte address of instruction
- misaligned  out  1  sticky fault flag (see Configuration)

## Operation
- Registers:
  - pc (next fetch address)
  - inflight (a request was issued last cycle and was not killed)
  - out register (inst_valid, instruction, pc_out)
  - skid register (skid_valid, data, pc)
  - req_pc (address of the in-flight request)
  - state ∈ {RUN, FAULT}
- Reset: pc=RESET_PC, state=RUN.
  - All valids, inflight, misaligned, instruction, pc_out and skid are cleared to 0.
- imem_req = (state==RUN) & !branch_taken & !skid_valid & !(inst_valid & !inst_ready). imem_addr = pc.
- On imem_req: req_pc<=pc, pc<=pc+4 (64-bit wrap to 0 allowed), inflight<=1. Otherwise inflight<=0.
- Response cycle (inflight=1): imem_rdata/req_pc go to the out register if it is empty or being consumed (inst_valid & inst_ready). Otherwise they go to the skid register.
- When out is consumed and skid_valid=1, the skid contents move to out and skid_valid clears.
- Redirect (branch_taken=1 in RUN):
  - target = branch_pc + (branch_imm << 1), computed in 64 bits with wrap.
  - pc<=target.
  - inflight, inst_valid and skid_valid are cleared at the same edge; the response arriving next cycle is discarded.
- Redirect has priority over stall and over any response landing in the same cycle.
- FAULT: no requests; inst_valid=0; branch_taken ignored. Only reset exits FAULT.
- Handshake rules:
  - While inst_valid & !inst_ready, instruction and pc_out are held stable.
  - inst_valid never drops without a transfer, except on redirect or reset.

## Timing
- Reset deasserted in cycle 0: imem_req with RESET_PC in cycle 0; inst_valid=1 from cycle 2.
- Steady state with inst_ready=1: one instruction per cycle, pc_out stepping by 4.
- branch_taken in cycle t: no request in t; request at target in t+1; target instruction valid in t+3.
- Stall: when inst_ready drops, at most one extra response lands in the skid register. Requests resume the cycle after both out and skid have drained, or as soon as out is consumed with skid empty.
- reset asserted mid-operation overrides everything at the next edge, including a pending redirect or skid content.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A redirect with target[1:0]!=0 moves to FAULT and sets misaligned=1 (sticky until reset).
  - pc is not updated, and the in-flight response is discarded.
- FETCH_MISALIGN_TRAP_EN undefined:
  - target[1:0] is forced to 2'b00 and the state stays RUN.
  - misaligned is tied to 0 and the FAULT state is not generated.

## Test plan
- Reset, RESET_PC=64'h100, inst_ready=1, memory returns the address as data -> pc_out 0x100, 0x104, 0x108… from cycle 2, one per cycle.
- Hold inst_ready=0 for 4 cycles mid-stream -> instruction/pc_out stable, at most one skid fill, no lost or duplicated PC after release.
- branch_taken with branch_pc=0x200, branch_imm=64'hFFFF_FFFF_FFFF_FFF8 (−8 halfwords) -> next valid pc_out=0x1F0 at t+3; the in-flight word at the old PC is never presented.
- Redirect while inst_valid=1, inst_ready=0, skid full -> both discarded; first valid afterwards is the target.
- branch_imm=64'h1 (target offset +2):
  - with FETCH_MISALIGN_TRAP_EN -> misaligned=1, imem_req stays 0 until reset.
  - without -> fetch continues at the aligned address (branch_pc+2)&~3.
- Assert reset during a stall with skid full -> the next edge clears all valids and the fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: RV64 PC + synchronous imem reads; optional FETCH_MISALIGN_TRAP_EN traps misaligned redirects.
// Latency: request to inst_valid 2 cycles; branch_taken to target inst_valid 3 cycles.
// Backpressure: inst_ready low holds out, one in-flight word parks in skid, requests stop until drained.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_pc,
  input  logic [63:0] branch_imm,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [63:0] pc_out,
  output logic        misaligned
);

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } slot_t;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [0:0] {RUN, FAULT} state_t;
`else
  typedef enum logic [0:0] {RUN} state_t;
`endif

  state_t      state;
  logic [63:0] pc;
  logic [63:0] req_pc;
  logic [63:0] target;
  logic        inflight;
  logic        skid_valid;
  logic        out_free;
  slot_t       skid;
  slot_t       resp;

  assign target    = branch_pc + (branch_imm << 1);
  assign out_free  = !inst_valid || inst_ready;
  assign imem_req  = (state == RUN) && !branch_taken && !skid_valid && out_free;
  assign imem_addr = pc;
  assign resp      = '{inst: imem_rdata, pc: req_pc};

`ifndef FETCH_MISALIGN_TRAP_EN
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      req_pc      <= '0;
      inflight    <= 1'b0;
      inst_valid  <= 1'b0;
      instruction <= '0;
      pc_out      <= '0;
      skid_valid  <= 1'b0;
      skid        <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misaligned  <= 1'b0;
`endif
    end else if (state == RUN) begin
      if (branch_taken) begin
        // Redirect flushes everything younger than the branch, including the word landing now.
        inflight   <= 1'b0;
        inst_valid <= 1'b0;
        skid_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (target[1:0] != 2'b00) begin
          state      <= FAULT;
          misaligned <= 1'b1;
        end else begin
          pc <= target;
        end
`else
        pc <= target & ~64'h3;
`endif
      end else begin
        inflight <= imem_req;
        if (imem_req) begin
          req_pc <= pc;
          pc     <= pc + 64'd4;
        end
        if (out_free) begin
          if (skid_valid) begin
            inst_valid  <= 1'b1;
            instruction <= skid.inst;
            pc_out      <= skid.pc;
            skid_valid  <= inflight;
            if (inflight) skid <= resp;
          end else if (inflight) begin
            inst_valid  <= 1'b1;
            instruction <= resp.inst;
            pc_out      <= resp.pc;
          end else begin
            inst_valid <= 1'b0;
          end
        end else if (inflight) begin
          skid       <= resp;
          skid_valid <= 1'b1;
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
    end else begin
      inflight   <= 1'b0;
      inst_valid <= 1'b0;
      skid_valid <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: expected PC stream per redirect/reset in a queue, monitor pops on every transfer.
module tb_fetch_unit;
  localparam logic [63:0] RPC = 64'h100;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_pc;
  logic [63:0] branch_imm;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [63:0] pc_out;
  logic        misaligned;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] stream_next;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .branch_taken(branch_taken), .branch_pc(branch_pc),
    .branch_imm(branch_imm), .inst_ready(inst_ready), .inst_valid(inst_valid),
    .instruction(instruction), .pc_out(pc_out), .misaligned(misaligned)
  );

  // Memory returns the low address bits as the instruction word.
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr[31:0];

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 16) begin
      exp_q.push_back(stream_next);
      stream_next = stream_next + 64'd4;
    end
  endtask

  task automatic restart(input logic [63:0] addr);
    exp_q.delete();
    stream_next = addr;
    topup();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    topup();
  endtask

  // Monitor: stream order on transfers, hold-while-stalled, address alignment.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_inst;
  logic [63:0] prev_pc;
  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_req === 1'b1) chk(imem_addr[1:0] == 2'b00, "addr_align", imem_addr, imem_addr & ~64'h3);
    if (branch_taken && !reset) chk(imem_req == 1'b0, "no_req_on_redirect", 64'(imem_req), 64'h0);
    if (reset || branch_taken) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk(inst_valid && instruction == prev_inst && pc_out == prev_pc, "stall_hold", pc_out, prev_pc);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL stream_extra: got %h, expected no transfer", pc_out);
        end else begin
          e = exp_q.pop_front();
          chk(pc_out == e && instruction == e[31:0], "stream", pc_out, e);
        end
      end
      prev_stall = inst_valid && !inst_ready;
      prev_inst  = instruction;
      prev_pc    = pc_out;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] p;
    reset = 1'b1; branch_taken = 1'b0; branch_pc = '0; branch_imm = '0; inst_ready = 1'b1;
    restart(RPC);
    repeat (3) step();
    chk(inst_valid == 1'b0, "rst_valid", 64'(inst_valid), 64'h0);
    chk(pc_out == 64'h0, "rst_pc_out", pc_out, 64'h0);
    chk(instruction == 32'h0, "rst_inst", 64'(instruction), 64'h0);
    chk(misaligned == 1'b0, "rst_misaligned", 64'(misaligned), 64'h0);

    // Cycle 0 after reset release: request at RESET_PC.
    reset = 1'b0;
    #1;
    chk(imem_req == 1'b1 && imem_addr == RPC, "c0_req", imem_addr, RPC);
    step();
    chk(inst_valid == 1'b0, "c1_valid", 64'(inst_valid), 64'h0);
    step();
    chk(inst_valid == 1'b1 && pc_out == RPC, "c2_first", pc_out, RPC);
    for (int i = 1; i <= 12; i++) begin
      step();
      chk(inst_valid == 1'b1 && pc_out == RPC + 64'(4 * i), "steady", pc_out, RPC + 64'(4 * i));
    end

    // Four-cycle stall: out holds p, p+4 parks in skid, no requests.
    p = RPC + 64'd48;
    inst_ready = 1'b0;
    #1;
    chk(imem_req == 1'b0, "stall_noreq0", 64'(imem_req), 64'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk(imem_req == 1'b0 && inst_valid == 1'b1 && pc_out == p, "stall_noreq", pc_out, p);
    end
    step();
    inst_ready = 1'b1;
    #1;
    chk(imem_req == 1'b0, "drain_skid_noreq", 64'(imem_req), 64'h0);
    step();
    chk(pc_out == p + 64'd4, "drain_skid_out", pc_out, p + 64'd4);
    chk(imem_req == 1'b1 && imem_addr == p + 64'd8, "resume_req", imem_addr, p + 64'd8);
    repeat (6) step();

    // Random readiness and aligned redirects.
    for (int i = 0; i < 600; i++) begin
      int v;
      step();
      inst_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 19) == 0) begin
        v = int'($urandom_range(0, 2047)) - 1024;
        branch_pc    = {$urandom, $urandom} & ~64'h3;
        branch_imm   = 64'(longint'(v)) & ~64'h1;
        branch_taken = 1'b1;
        restart(branch_pc + branch_imm * 64'd2);
      end else begin
        branch_taken = 1'b0;
      end
    end
    step();
    branch_taken = 1'b0;
    inst_ready   = 1'b1;
    repeat (8) step();

    // Backward branch: 0x200 + (-8 halfwords) = 0x1F0.
    branch_pc = 64'h200; branch_imm = 64'hFFFF_FFFF_FFFF_FFF8; branch_taken = 1'b1;
    restart(64'h1F0);
    #1;
    chk(imem_req == 1'b0, "br_t_noreq", 64'(imem_req), 64'h0);
    step();
    branch_taken = 1'b0;
    #1;
    chk(inst_valid == 1'b0, "br_t1_valid", 64'(inst_valid), 64'h0);
    chk(imem_req == 1'b1 && imem_addr == 64'h1F0, "br_t1_req", imem_addr, 64'h1F0);
    step();
    chk(inst_valid == 1'b0, "br_t2_valid", 64'(inst_valid), 64'h0);
    step();
    chk(inst_valid == 1'b1 && pc_out == 64'h1F0, "br_t3_target", pc_out, 64'h1F0);
    repeat (4) step();

    // Redirect with out stalled and skid full.
    inst_ready = 1'b0;
    repeat (3) step();
    branch_pc = 64'h800; branch_imm = 64'h10; branch_taken = 1'b1;
    restart(64'h820);
    step();
    branch_taken = 1'b0;
    step();
    chk(inst_valid == 1'b0, "skidbr_flush", 64'(inst_valid), 64'h0);
    step();
    chk(inst_valid == 1'b1 && pc_out == 64'h820, "skidbr_target", pc_out, 64'h820);
    inst_ready = 1'b1;
    repeat (5) step();

    // Reset during a stall with skid full.
    inst_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    restart(RPC);
    step();
    chk(inst_valid == 1'b0 && imem_addr == RPC, "midrst_clear", imem_addr, RPC);
    reset = 1'b0;
    #1;
    chk(imem_req == 1'b1 && imem_addr == RPC, "midrst_req", imem_addr, RPC);
    step();
    step();
    chk(inst_valid == 1'b1 && pc_out == RPC, "midrst_first", pc_out, RPC);
    inst_ready = 1'b1;
    repeat (5) step();

    // Redirect to branch_pc + 2.
    branch_pc = 64'h300; branch_imm = 64'h1; branch_taken = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
    restart(64'h0);
    exp_q.delete();
    step();
    branch_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk(misaligned == 1'b1 && imem_req == 1'b0 && inst_valid == 1'b0, "fault_hold", 64'(imem_req), 64'h0);
      step();
    end
    reset = 1'b1;
    restart(RPC);
    step();
    chk(misaligned == 1'b0, "fault_rst", 64'(misaligned), 64'h0);
    reset = 1'b0;
    step();
    step();
    chk(inst_valid == 1'b1 && pc_out == RPC, "fault_restart", pc_out, RPC);
`else
    restart(64'h300);
    step();
    branch_taken = 1'b0;
    step();
    step();
    chk(inst_valid == 1'b1 && pc_out == 64'h300 && misaligned == 1'b0, "mis_aligned_fetch", pc_out, 64'h300);
`endif
    repeat (6) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
